// File: rtl/cv32e40p_apu_core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_apu_core_pkg
// Description : Shared types, op-class encodings and latency lookup for the
//               APU responder.
// Revision    : 1.0 - initial release
// ============================================================================
package cv32e40p_apu_core_pkg;

   // Responder FSM state encoding
   typedef enum logic [1:0] {
      RESP_IDLE = 2'd0,
      RESP_WAIT = 2'd1,
      RESP_BUSY = 2'd2
   } apu_resp_state_e;

   // Operation classes selected by op[1:0]
   localparam logic [1:0] APU_CLS_ADD  = 2'd0;
   localparam logic [1:0] APU_CLS_SUB  = 2'd1;
   localparam logic [1:0] APU_CLS_XOR  = 2'd2;
   localparam logic [1:0] APU_CLS_PACK = 2'd3;

   // Latency of a class, picked from a packed table {LAT3,LAT2,LAT1,LAT0}
   function automatic logic [3:0] apu_resp_lat(input logic [1:0]  cls,
                                                input logic [15:0] lat_tab);
      logic [3:0] lat;
      case (cls)
         APU_CLS_ADD:  lat = lat_tab[3:0];
         APU_CLS_SUB:  lat = lat_tab[7:4];
         APU_CLS_XOR:  lat = lat_tab[11:8];
         default:      lat = lat_tab[15:12];
      endcase
      return lat;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cv32e40p_apu_resp_datapath.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_apu_resp_datapath
// Description : Combinational result and upstream flags for one APU payload.
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_apu_resp_datapath
   import cv32e40p_apu_core_pkg::*;
#(
   parameter int APU_NARGS    = 3,
   parameter int APU_WOP      = 6,
   parameter int APU_NUSFLAGS = 5
) (
   input  logic [APU_WOP-1:0]        i_op,
   input  logic [APU_NARGS*32-1:0]   i_operands,
   output logic [31:0]               o_result,
   output logic [APU_NUSFLAGS-1:0]   o_flags
);

   logic [31:0] w_a;
   logic [31:0] w_b;
   logic [31:0] w_c;
   logic        w_unused_op;

   assign w_a = i_operands[31:0];
   assign w_b = i_operands[63:32];
   assign w_c = i_operands[95:64];

   // Only op[4:0] carry meaning here; the top bit is ignored
   assign w_unused_op = ^i_op;

   // Result per class, wrapping modulo 2^32
   always_comb begin
      o_result = 32'd0;
      case (i_op[1:0])
         APU_CLS_ADD:  o_result = w_a + w_b;
         APU_CLS_SUB:  o_result = w_a - w_b;
         APU_CLS_XOR:  o_result = w_a ^ w_b ^ w_c;
         APU_CLS_PACK: o_result = {w_a[15:0], w_b[15:0]};
         default:      o_result = 32'd0;
      endcase
   end

   // Flags: op modifier bits, sign and zero of the result
   always_comb begin
      o_flags = APU_NUSFLAGS'({i_op[4:2], o_result[31], (o_result == 32'd0)});
   end

endmodule
`default_nettype wire

// File: rtl/cv32e40p_apu_responder.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_apu_responder
// Description : Responder for the core's APU req/gnt/rvalid interface with a
//               configurable grant delay, per-class latency and a sticky
//               requester protocol-violation flag. One transaction in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_apu_responder
   import cv32e40p_apu_core_pkg::*;
#(
   parameter int APU_NARGS    = 3,
   parameter int APU_WOP      = 6,
   parameter int APU_NDSFLAGS = 15,
   parameter int APU_NUSFLAGS = 5,
   parameter int GNT_DLY      = 0,
   parameter int LAT_C0       = 1,
   parameter int LAT_C1       = 2,
   parameter int LAT_C2       = 4,
   parameter int LAT_C3       = 8
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      apu_req_i,
   input  logic [APU_NARGS*32-1:0]   apu_operands_i,
   input  logic [APU_WOP-1:0]        apu_op_i,
   input  logic [APU_NDSFLAGS-1:0]   apu_flags_i,
   output logic                      apu_gnt_o,
   output logic                      apu_rvalid_o,
   output logic [31:0]               apu_result_o,
   output logic [APU_NUSFLAGS-1:0]   apu_flags_o,
   output logic                      busy_o,
   output logic                      proto_err_o
);

   localparam logic [1:0]  c_ST_IDLE = RESP_IDLE;
   localparam logic [1:0]  c_ST_WAIT = RESP_WAIT;
   localparam logic [1:0]  c_ST_BUSY = RESP_BUSY;
   localparam logic [3:0]  c_GNT_DLY = 4'(GNT_DLY);
   localparam logic [15:0] c_LAT_TAB = {4'(LAT_C3), 4'(LAT_C2), 4'(LAT_C1), 4'(LAT_C0)};

   logic [1:0]                r_state;
   logic [3:0]                r_wait_cnt;
   logic [3:0]                r_lat_cnt;
   logic [APU_WOP-1:0]        r_op;
   logic [APU_NARGS*32-1:0]   r_operands;
   logic [APU_NDSFLAGS-1:0]   r_ds_flags;
   logic                      r_rvalid;
   logic [31:0]               r_result;
   logic [APU_NUSFLAGS-1:0]   r_flags;
   logic                      r_proto_err;

   logic                      w_accept;
   logic [3:0]                w_lat;
   logic                      w_rvalid_set;
   logic [APU_WOP-1:0]        w_dp_op;
   logic [APU_NARGS*32-1:0]   w_dp_operands;
   logic [31:0]               w_dp_result;
   logic [APU_NUSFLAGS-1:0]   w_dp_flags;
   logic                      w_payload_diff;
   logic                      w_unused_ds;

   assign apu_gnt_o    = apu_req_i && (r_state != c_ST_BUSY) && (r_wait_cnt == c_GNT_DLY);
   assign w_accept     = apu_gnt_o;
   assign w_lat        = apu_resp_lat(apu_op_i[1:0], c_LAT_TAB);
   assign w_payload_diff = (apu_op_i != r_op) || (apu_operands_i != r_operands);

   // rvalid is raised for the next cycle either by a single-cycle accept or
   // by the last BUSY cycle of a multicycle transaction
   assign w_rvalid_set = (w_accept && (w_lat == 4'd1)) ||
                         ((r_state == c_ST_BUSY) && (r_lat_cnt == 4'd1));

   // A single-cycle accept needs its result at the same edge the payload is
   // latched, so the live inputs feed the datapath during accept
   assign w_dp_op       = w_accept ? apu_op_i       : r_op;
   assign w_dp_operands = w_accept ? apu_operands_i : r_operands;

   assign w_unused_ds = ^r_ds_flags;

   cv32e40p_apu_resp_datapath #(
      .APU_NARGS    (APU_NARGS),
      .APU_WOP      (APU_WOP),
      .APU_NUSFLAGS (APU_NUSFLAGS)
   ) u_datapath (
      .i_op       (w_dp_op),
      .i_operands (w_dp_operands),
      .o_result   (w_dp_result),
      .o_flags    (w_dp_flags)
   );

   // FSM and latency countdown; r_lat_cnt holds remaining BUSY cycles
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= c_ST_IDLE;
         r_lat_cnt <= 4'd0;
      end else begin
         case (r_state)
            c_ST_IDLE, c_ST_WAIT: begin
               if (w_accept) begin
                  if (w_lat > 4'd1) begin
                     r_state   <= c_ST_BUSY;
                     r_lat_cnt <= w_lat - 4'd1;
                  end else begin
                     r_state   <= c_ST_IDLE;
                  end
               end else if (apu_req_i) begin
                  r_state <= c_ST_WAIT;
               end else begin
                  r_state <= c_ST_IDLE;
               end
            end
            c_ST_BUSY: begin
               r_lat_cnt <= r_lat_cnt - 4'd1;
               if (r_lat_cnt == 4'd1) begin
                  r_state <= c_ST_IDLE;
               end
            end
            default: r_state <= c_ST_IDLE;
         endcase
      end
   end

   // Grant-delay counter: cycles of req held outside BUSY, saturating
   always_ff @(posedge clk_i) begin
      if (rst_i || (r_state == c_ST_BUSY) || !apu_req_i || w_accept) begin
         r_wait_cnt <= 4'd0;
      end else if (r_wait_cnt != c_GNT_DLY) begin
         r_wait_cnt <= r_wait_cnt + 4'd1;
      end
   end

   // Payload latch: first request cycle (reference for the checker) and accept
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_op       <= '0;
         r_operands <= '0;
         r_ds_flags <= '0;
      end else if (w_accept || ((r_state == c_ST_IDLE) && apu_req_i)) begin
         r_op       <= apu_op_i;
         r_operands <= apu_operands_i;
         r_ds_flags <= apu_flags_i;
      end
   end

   // Response registers: pulse rvalid and hold result/flags until next rvalid
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rvalid <= 1'b0;
         r_result <= 32'd0;
         r_flags  <= '0;
      end else begin
         r_rvalid <= w_rvalid_set;
         if (w_rvalid_set) begin
            r_result <= w_dp_result;
            r_flags  <= w_dp_flags;
         end
      end
   end

   // Sticky checker: while waiting for grant, req must stay high and stable
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_proto_err <= 1'b0;
      end else if ((r_state == c_ST_WAIT) && (!apu_req_i || w_payload_diff)) begin
         r_proto_err <= 1'b1;
      end
   end

   assign apu_rvalid_o = r_rvalid;
   assign apu_result_o = r_result;
   assign apu_flags_o  = r_flags;
   assign busy_o       = (r_state == c_ST_BUSY);
   assign proto_err_o  = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_apu_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cv32e40p_apu_responder
// Description : Self-checking bench: two responders (grant delay 0 and 3)
//               compared every cycle against a transaction-level model, plus
//               directed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cv32e40p_apu_responder;

   logic        clk;
   logic        rst    [2];
   logic        req    [2];
   logic [95:0] opnds  [2];
   logic [5:0]  op     [2];
   logic [14:0] dsf    [2];
   logic        gnt    [2];
   logic        rvalid [2];
   logic [31:0] res    [2];
   logic [4:0]  flg    [2];
   logic        busy   [2];
   logic        perr   [2];

   int total = 0;
   int bad   = 0;

   cv32e40p_apu_responder #(.GNT_DLY(0)) u_d0 (
      .clk_i(clk), .rst_i(rst[0]), .apu_req_i(req[0]), .apu_operands_i(opnds[0]),
      .apu_op_i(op[0]), .apu_flags_i(dsf[0]), .apu_gnt_o(gnt[0]), .apu_rvalid_o(rvalid[0]),
      .apu_result_o(res[0]), .apu_flags_o(flg[0]), .busy_o(busy[0]), .proto_err_o(perr[0])
   );

   cv32e40p_apu_responder #(.GNT_DLY(3)) u_d3 (
      .clk_i(clk), .rst_i(rst[1]), .apu_req_i(req[1]), .apu_operands_i(opnds[1]),
      .apu_op_i(op[1]), .apu_flags_i(dsf[1]), .apu_gnt_o(gnt[1]), .apu_rvalid_o(rvalid[1]),
      .apu_result_o(res[1]), .apu_flags_o(flg[1]), .busy_o(busy[1]), .proto_err_o(perr[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input int k, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s inst=%0d t=%0t got=%h exp=%h", nm, k, $time, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic logic [31:0] m_result(input logic [5:0] o, input logic [95:0] x);
      logic [31:0] a, b, c;
      a = x[31:0]; b = x[63:32]; c = x[95:64];
      case (o[1:0])
         2'd0:    return a + b;
         2'd1:    return a - b;
         2'd2:    return a ^ b ^ c;
         default: return {a[15:0], b[15:0]};
      endcase
   endfunction

   function automatic logic [4:0] m_flags(input logic [5:0] o, input logic [31:0] r);
      return {o[4:2], r[31], (r == 32'd0)};
   endfunction

   int          dly [2] = '{0, 3};
   int          cyc = 0;
   bit          mvalid [2];
   bit          pend [2];
   int          due [2];
   logic [31:0] pend_res [2];
   logic [4:0]  pend_flg [2];
   logic [31:0] shown_res [2];
   logic [4:0]  shown_flg [2];
   int          streak [2];
   bit          in_wait [2];
   logic [5:0]  first_op [2];
   logic [95:0] first_opnd [2];
   bit          proto [2];

   initial begin
      for (int k = 0; k < 2; k++) begin
         mvalid[k] = 0; pend[k] = 0; due[k] = 0; streak[k] = 0; in_wait[k] = 0; proto[k] = 0;
         shown_res[k] = 0; shown_flg[k] = 0;
      end
   end

   // Compare, then advance the model across the coming clock edge
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         bit b_e, rv_e, g_e;
         int sc;
         b_e  = pend[k] && (cyc < due[k]);
         rv_e = pend[k] && (cyc == due[k]);
         if (rv_e) begin
            shown_res[k] = pend_res[k];
            shown_flg[k] = pend_flg[k];
            pend[k]      = 0;
         end
         sc  = (req[k] && !b_e) ? streak[k] + 1 : 0;
         g_e = req[k] && !b_e && (sc > dly[k]);
         if (mvalid[k]) begin
            check("gnt",    k, 32'(gnt[k]),    32'(g_e));
            check("rvalid", k, 32'(rvalid[k]), 32'(rv_e));
            check("result", k, res[k],         shown_res[k]);
            check("flags",  k, 32'(flg[k]),    32'(shown_flg[k]));
            check("busy",   k, 32'(busy[k]),   32'(b_e));
            check("perr",   k, 32'(perr[k]),   32'(proto[k]));
         end
         if (rst[k]) begin
            mvalid[k] = 1; pend[k] = 0; streak[k] = 0; in_wait[k] = 0; proto[k] = 0;
            shown_res[k] = 0; shown_flg[k] = 0;
         end else begin
            if (in_wait[k] && (!req[k] || op[k] != first_op[k] || opnds[k] != first_opnd[k]))
               proto[k] = 1;
            if (!in_wait[k] && req[k] && !b_e) begin
               first_op[k]   = op[k];
               first_opnd[k] = opnds[k];
            end
            if (g_e) begin
               pend[k]     = 1;
               due[k]      = cyc + (1 << op[k][1:0]);
               pend_res[k] = m_result(op[k], opnds[k]);
               pend_flg[k] = m_flags(op[k], pend_res[k]);
            end
            streak[k]  = g_e ? 0 : sc;
            in_wait[k] = req[k] && !b_e && !g_e;
         end
      end
      cyc++;
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input int k, input logic r, input logic [5:0] o,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      req[k]   = r;
      op[k]    = o;
      opnds[k] = {c, b, a};
      dsf[k]   = 15'($urandom);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      int ng, nr;
      bit prev_g;
      bit acc_prev [2];
      for (int k = 0; k < 2; k++) begin
         rst[k] = 1; drv(k, 0, 6'd0, 0, 0, 0);
      end
      repeat (3) step();
      rst[0] = 0; rst[1] = 0;
      step();

      // single-cycle add: gnt same cycle, rvalid next cycle
      drv(0, 1, 6'd0, 5, 7, 0); #1;
      check("t1_gnt", 0, 32'(gnt[0]), 1);
      step(); drv(0, 0, 6'd0, 0, 0, 0); #1;
      check("t1_rvalid", 0, 32'(rvalid[0]), 1);
      check("t1_result", 0, res[0], 32'd12);
      check("t1_flags",  0, 32'(flg[0]), 0);
      step(); #1;
      check("t1_rvalid_off", 0, 32'(rvalid[0]), 0);

      // latency-2 subtract wraps; a queued add is granted in the rvalid cycle
      step(); drv(0, 1, 6'd1, 0, 1, 0); #1;
      check("t2_gnt", 0, 32'(gnt[0]), 1);
      step(); drv(0, 1, 6'd0, 3, 4, 0); #1;
      check("t2_gnt_busy", 0, 32'(gnt[0]), 0);
      check("t2_busy",     0, 32'(busy[0]), 1);
      check("t2_rv_early", 0, 32'(rvalid[0]), 0);
      step(); #1;
      check("t2_rvalid", 0, 32'(rvalid[0]), 1);
      check("t2_result", 0, res[0], 32'hFFFF_FFFF);
      check("t2_flags",  0, 32'(flg[0]), 32'h02);
      check("t2_gnt_b2b", 0, 32'(gnt[0]), 1);
      step(); drv(0, 0, 6'd0, 0, 0, 0); #1;
      check("t2_rvalid2", 0, 32'(rvalid[0]), 1);
      check("t2_result2", 0, res[0], 32'd7);

      // latency-8 pack with a second request queued behind it
      step(); drv(0, 1, 6'd3, 32'h1234_ABCD, 32'h5678_0001, 0); #1;
      check("t3_gnt", 0, 32'(gnt[0]), 1);
      for (int i = 1; i < 8; i++) begin
         step(); drv(0, 1, 6'd3, 2, 3, 0); #1;
         check("t3_gnt_hold", 0, 32'(gnt[0]), 0);
         check("t3_rv_hold",  0, 32'(rvalid[0]), 0);
      end
      step(); #1;
      check("t3_rvalid", 0, 32'(rvalid[0]), 1);
      check("t3_result", 0, res[0], 32'hABCD_0001);
      check("t3_gnt2",   0, 32'(gnt[0]), 1);
      for (int i = 1; i < 8; i++) begin
         step(); drv(0, 0, 6'd0, 0, 0, 0); #1;
         check("t3_rv2_hold", 0, 32'(rvalid[0]), 0);
         check("t3_result_held", 0, res[0], 32'hABCD_0001);
      end
      step(); #1;
      check("t3_rvalid2", 0, 32'(rvalid[0]), 1);
      check("t3_result2", 0, res[0], 32'h0002_0003);

      // grant delay 3: granted on the 4th held cycle
      step(); drv(1, 1, 6'd0, 1, 1, 0);
      for (int i = 1; i <= 4; i++) begin
         #1; check("t4_gnt_dly", 1, 32'(gnt[1]), (i == 4) ? 1 : 0);
         if (i < 4) step();
      end
      step(); drv(1, 0, 6'd0, 0, 0, 0); #1;
      check("t4_rvalid", 1, 32'(rvalid[1]), 1);
      check("t4_result", 1, res[1], 32'd2);
      check("t4_perr0",  1, 32'(perr[1]), 0);
      // op changed in second request cycle
      step(); drv(1, 1, 6'd2, 9, 9, 9);
      step(); drv(1, 1, 6'd0, 9, 9, 9); #1;
      check("t4_gnt_c2", 1, 32'(gnt[1]), 0);
      step(); #1;
      check("t4_perr1", 1, 32'(perr[1]), 1);
      step(); #1;
      check("t4_gnt_c4", 1, 32'(gnt[1]), 1);
      step(); drv(1, 0, 6'd0, 0, 0, 0);
      repeat (5) step();
      #1; check("t4_perr_sticky", 1, 32'(perr[1]), 1);

      // reset inside a BUSY transaction suppresses its rvalid
      step(); drv(0, 1, 6'd3, 1, 2, 0); #1;
      check("t5_gnt", 0, 32'(gnt[0]), 1);
      step(); drv(0, 0, 6'd0, 0, 0, 0);
      repeat (3) step();
      rst[0] = 1;
      step(); rst[0] = 0;
      for (int i = 0; i < 12; i++) begin
         #1; check("t5_no_rvalid", 0, 32'(rvalid[0]), 0);
         step();
      end
      drv(0, 1, 6'd0, 9, 1, 0); #1;
      check("t5_gnt_after", 0, 32'(gnt[0]), 1);
      step(); drv(0, 0, 6'd0, 0, 0, 0); #1;
      check("t5_rvalid_after", 0, 32'(rvalid[0]), 1);
      check("t5_result_after", 0, res[0], 32'd10);

      // ten back-to-back single-cycle requests
      ng = 0; nr = 0; prev_g = 0;
      for (int i = 0; i < 11; i++) begin
         step();
         if (i < 10) drv(0, 1, 6'd0, i, 100, 0);
         else        drv(0, 0, 6'd0, 0, 0, 0);
         #1;
         if (i < 10) check("t6_gnt", 0, 32'(gnt[0]), 1);
         check("t6_rv_follows", 0, 32'(rvalid[0]), 32'(prev_g));
         ng += int'(gnt[0]); nr += int'(rvalid[0]);
         prev_g = gnt[0];
      end
      check("t6_ngnt",   0, ng, 10);
      check("t6_nrvalid", 0, nr, 10);

      // randomized traffic on both instances
      acc_prev[0] = 0; acc_prev[1] = 0;
      for (int n = 0; n < 3000; n++) begin
         step();
         for (int k = 0; k < 2; k++) begin
            rst[k] = ($urandom_range(0, 399) == 0);
            if (req[k] && !acc_prev[k]) begin
               if ($urandom_range(0, 99) < 4) req[k] = 0;
               if ($urandom_range(0, 99) < 3) opnds[k] = opnds[k] ^ (96'(1) << $urandom_range(0, 95));
            end else begin
               req[k] = ($urandom_range(0, 99) < 60);
               op[k]  = 6'($urandom);
               if ($urandom_range(0, 2) == 0)
                  opnds[k] = {32'($urandom_range(0, 3)), 32'($urandom_range(0, 3)), 32'($urandom_range(0, 3))};
               else
                  opnds[k] = {$urandom, $urandom, $urandom};
            end
         end
         #1;
         for (int k = 0; k < 2; k++) acc_prev[k] = req[k] && gnt[k];
      end
      step();
      drv(0, 0, 6'd0, 0, 0, 0); drv(1, 0, 6'd0, 0, 0, 0);
      rst[0] = 0; rst[1] = 0;
      repeat (20) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
